ab_transfer_sequencer: RTL
==========================

// Module: ab_transfer_sequencer
// PURPOSE
//  Sequences the two-memory datapath for one transfer job.
//  Fills memory A from an input stream under a valid/ready handshake, then reads A back sequentially.
//  Writes one combined result per word pair into memory B, after the datapath pipeline latency.
//  Signals completion with a one-cycle done pulse.
//  Replaces fixed-schedule strobe generation with a start/done, stall-tolerant FSM.
// PARAMETERS
//  DEPTH_A   8   words loaded into / read from A per job; must be even and >= 2
//  ADDR_W    3   address width; 2**ADDR_W >= DEPTH_A
//  PIPE_LAT  2   cycles from the A read (rd_en_a) of a pair's 2nd word to its result at B; must be >= 1
// PORTS
//  clock     in   1       rising-edge clock
//  Reset     in   1       synchronous, active-high reset
//  start     in   1       job request; sampled only in IDLE
//  in_valid  in   1       input word present for A
//  in_ready  out  1       sequencer accepts input word (LOAD only)
//  wea       out  1       write enable, memory A (= in_valid & in_ready)
//  rd_en_a   out  1       read enable, memory A
//  addr_a    out  ADDR_W  memory A address (shared by write and read)
//  web       out  1       write enable, memory B
//  addr_b    out  ADDR_W  memory B address
//  busy      out  1       state != IDLE
//  done      out  1       one-cycle pulse at job end
// BEHAVIOUR
//  Reset (sync, priority over all): state=IDLE, addr_a=0, addr_b=0, tag line cleared.
//   Every output is 0 in the cycle after the reset edge.
//  States: IDLE -> LOAD -> READ -> FLUSH -> DONE -> IDLE.
//  IDLE: all outputs 0. start=1 at an edge -> LOAD, addr_a=0, addr_b=0.
//  LOAD: in_ready=1; wea is combinational = in_valid.
//   Each accepted word: addr_a += 1 at the edge.
//   in_valid=0 stalls; addr_a holds and no write occurs.
//   Accept at addr_a = DEPTH_A-1 -> READ, addr_a=0.
//  READ: rd_en_a=1 for exactly DEPTH_A consecutive cycles, with addr_a = 0..DEPTH_A-1.
//   No stall.
//   After the cycle with addr_a = DEPTH_A-1 -> FLUSH.
//  Tag line: a PIPE_LAT-stage shift register.
//   Input = rd_en_a & addr_a[0].
//   web = output of the last stage, so a tag entering in cycle t gives web=1 in cycle t+PIPE_LAT.
//   addr_b += 1 at each edge where web=1; addr_b is stable during the web cycle.
//  FLUSH: lasts exactly PIPE_LAT cycles; the final web falls in the last FLUSH cycle -> DONE.
//  DONE: done=1, busy=1 for one cycle -> IDLE.
//   addr_b = DEPTH_A/2 in DONE; addr_b is cleared on the next start.
//  busy: 1 in LOAD, READ, FLUSH and DONE.
//  start outside IDLE: ignored, with no queuing.
//   start held high: a new job begins in the cycle after DONE returns to IDLE.
//  Address wrap: addr_a never exceeds DEPTH_A-1. addr_b never exceeds DEPTH_A/2-1 while web=1.
//  Reset mid-job: the job is abandoned immediately.
//   No further wea/web pulses. The tag line is flushed, so no stale web appears after reset.
//  Exactly DEPTH_A wea, DEPTH_A rd_en_a and DEPTH_A/2 web pulses per completed job.
// TESTING (DEPTH_A=8, PIPE_LAT=2; cycle n = cycle after the nth edge, start=1 in cycle 0)
//  1 Nominal, in_valid held 1:
//    wea in cycles 1-8, addr_a 0-7.
//    rd_en_a in cycles 9-16, addr_a 0-7.
//    web in cycles 12,14,16,18, addr_b 0,1,2,3.
//    done in cycle 19; busy=0 in cycle 20.
//  2 Input stall: in_valid=0 in cycles 3-5 -> addr_a holds at 2, no wea.
//    LOAD ends in cycle 11; done in cycle 22.
//  3 Reset=1 in cycle 13 -> cycle 14: all outputs 0 and IDLE.
//    No web in cycles 14-18.
//  4 start=1 in cycles 1-20 -> ignored while busy; second job's LOAD begins in cycle 21.
//  5 Sync reset: Reset=1 asserted with start=1 -> stays IDLE; all outputs 0.
//  6 PIPE_LAT=1: web in cycles 11,13,15,17; done in cycle 18.

Source files
------------

// File: rtl/ab_transfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ab_transfer_sequencer
//  Description : Runs one transfer job through the two-memory datapath.
//                Memory A is filled from an input stream under a
//                valid/ready handshake and then read back in address order.
//                For every pair of words read from A, one combined result is
//                written to memory B once the datapath pipeline latency has
//                elapsed. The end of the job is marked by a one-cycle done
//                pulse.
//  Ports       : clock     - rising-edge clock
//                Reset     - synchronous, active-high reset
//                start     - job request, sampled only while idle
//                in_valid  - input word present for memory A
//                in_ready  - input word accepted (load phase only)
//                wea       - memory A write enable
//                rd_en_a   - memory A read enable
//                addr_a    - memory A address (write and read)
//                web       - memory B write enable
//                addr_b    - memory B address
//                busy      - a job is in progress
//                done      - one-cycle pulse at the end of a job
//  Revision    : 1.0 - initial release
// ============================================================================
module ab_transfer_sequencer #(
  parameter int DEPTH_A  = 8,
  parameter int ADDR_W   = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wea,
  output logic              rd_en_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic              web,
  output logic [ADDR_W-1:0] addr_b,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              c_FC_W       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ADDR_W-1:0] c_LAST_A   = ADDR_W'(DEPTH_A - 1);
  localparam logic [c_FC_W-1:0] c_FLUSH_LAST = c_FC_W'(PIPE_LAT - 1);

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [ADDR_W-1:0]   r_addr_a;
  logic [ADDR_W-1:0]   r_addr_b;
  logic [c_FC_W-1:0]   r_flush_cnt;
  logic [PIPE_LAT-1:0] r_tag;

  logic w_last_a;
  logic w_accept;
  logic w_tag_in;
  logic w_web;

  assign w_last_a = (r_addr_a == c_LAST_A);
  assign w_accept = (r_state == S_LOAD) & in_valid;
  // A pair completes on its odd-addressed word; that read launches the tag.
  assign w_tag_in = (r_state == S_READ) & r_addr_a[0];
  assign w_web    = r_tag[PIPE_LAT-1];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (w_accept && w_last_a) w_next = S_READ;
      S_READ:  if (w_last_a) w_next = S_FLUSH;
      // Reads end on an odd address, so the last tag retires exactly
      // PIPE_LAT cycles later, in the final flush cycle.
      S_FLUSH: if (r_flush_cnt == c_FLUSH_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    wea      = 1'b0;
    rd_en_a  = 1'b0;
    done     = 1'b0;
    busy     = (r_state != S_IDLE);
    addr_a   = '0;
    addr_b   = '0;
    web      = w_web;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        wea      = in_valid;
        addr_a   = r_addr_a;
        addr_b   = r_addr_b;
      end
      S_READ: begin
        rd_en_a  = 1'b1;
        addr_a   = r_addr_a;
        addr_b   = r_addr_b;
      end
      S_FLUSH: begin
        addr_a   = r_addr_a;
        addr_b   = r_addr_b;
      end
      S_DONE: begin
        done     = 1'b1;
        addr_a   = r_addr_a;
        addr_b   = r_addr_b;
      end
      default: begin
        // Idle: every output quiet; addr_b register may still hold the
        // previous job's count until the next start clears it.
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address counters and flush counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (Reset) begin
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_web) begin
        r_addr_b <= r_addr_b + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr_a <= '0;
            r_addr_b <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_addr_a <= w_last_a ? '0 : r_addr_a + 1'b1;
          end
        end
        S_READ: begin
          r_addr_a    <= w_last_a ? '0 : r_addr_a + 1'b1;
          r_flush_cnt <= '0;
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Tag line: models the datapath latency from a pair's second read to its
  // result at memory B.
  // --------------------------------------------------------------------------
  generate
    if (PIPE_LAT == 1) begin : g_tag_single
      always_ff @(posedge clock) begin
        if (Reset) begin
          r_tag <= '0;
        end else begin
          r_tag <= w_tag_in;
        end
      end
    end else begin : g_tag_multi
      always_ff @(posedge clock) begin
        if (Reset) begin
          r_tag <= '0;
        end else begin
          r_tag <= {r_tag[PIPE_LAT-2:0], w_tag_in};
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
